// File: rtl/ram_burst_scheduler.sv
// Splits write/read requests into page-safe, length-limited linear bursts for the PSRAM port unit.
// Writes and reads are arbitrated round-robin, and each request is acknowledged once every burst has completed.
module ram_burst_scheduler #(
  parameter int pAdrsWidth = 23,
  parameter int pLenWidth  = 12,
  parameter int pPageBits  = 9,
  parameter int pMaxBurst  = 64
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iWrReq,
  input  logic [pAdrsWidth-1:0] iWrAdrs,
  input  logic [pLenWidth-1:0]  iWrLen,
  output logic                  oWrAck,
  input  logic                  iRdReq,
  input  logic [pAdrsWidth-1:0] iRdAdrs,
  input  logic [pLenWidth-1:0]  iRdLen,
  output logic                  oRdAck,
  output logic                  oCmdValid,
  output logic                  oCmdWrite,
  output logic [pAdrsWidth-1:0] oCmdAdrs,
  output logic [pLenWidth-1:0]  oCmdLen,
  input  logic                  iCmdReady,
  input  logic                  iCmdDone,
  output logic                  oBusy
);

  // One extra bit over the wider operand, so a full page (2^pPageBits) fits without truncation
  localparam int pCalcWidth = ((pLenWidth > pPageBits) ? pLenWidth : pPageBits) + 1;

  typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAIT, ACK} stateT;

  stateT                  state, nextState;
  logic [pAdrsWidth-1:0]  adrs;
  logic [pLenWidth-1:0]   remaining;
  logic                   dirWrite;
  logic                   lastWasRead;
  logic [pAdrsWidth-1:0]  cmdAdrs;
  logic [pLenWidth-1:0]   cmdLen;
  logic                   cmdWrite;

  logic                   anyReq;
  logic                   grantWrite;
  logic [pAdrsWidth-1:0]  selAdrs;
  logic [pLenWidth-1:0]   selLen;
  logic                   handshake;
  logic [pCalcWidth-1:0]  pageRem;
  logic [pCalcWidth-1:0]  segWide;
  logic [pLenWidth-1:0]   segLen;

  // Request selection: on a tie, grant the side that was not served last
  always_comb begin
    anyReq     = iWrReq | iRdReq;
    grantWrite = (iWrReq & iRdReq) ? lastWasRead : iWrReq;
    selAdrs    = grantWrite ? iWrAdrs : iRdAdrs;
    selLen     = grantWrite ? iWrLen : iRdLen;
    handshake  = (state == ISSUE) & iCmdReady;
  end

  // Segment length is the smallest of the remaining words, the burst limit and the room left in the page
  always_comb begin
    pageRem = (pCalcWidth'(1) << pPageBits) - pCalcWidth'(adrs[pPageBits-1:0]);
    segWide = pCalcWidth'(remaining);
    if (pCalcWidth'(pMaxBurst) < segWide) segWide = pCalcWidth'(pMaxBurst);
    if (pageRem < segWide) segWide = pageRem;
    segLen = pLenWidth'(segWide);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (anyReq) nextState = (selLen == '0) ? ACK : CALC;
      CALC:  nextState = ISSUE;
      ISSUE: if (handshake) nextState = WAIT;
      WAIT:  if (iCmdDone) nextState = (remaining == '0) ? ACK : CALC;
      ACK:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    oCmdValid = (state == ISSUE);
    oWrAck    = (state == ACK) &  dirWrite;
    oRdAck    = (state == ACK) & ~dirWrite;
    oBusy     = (state != IDLE);
    oCmdAdrs  = cmdAdrs;
    oCmdLen   = cmdLen;
    oCmdWrite = cmdWrite;
  end

  // Request context and the command fields, which stay frozen from CALC until the burst is accepted
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      adrs        <= '0;
      remaining   <= '0;
      dirWrite    <= 1'b0;
      lastWasRead <= 1'b1;
      cmdAdrs     <= '0;
      cmdLen      <= '0;
      cmdWrite    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            adrs      <= selAdrs;
            remaining <= selLen;
            dirWrite  <= grantWrite;
          end
        end
        CALC: begin
          cmdAdrs  <= adrs;
          cmdLen   <= segLen;
          cmdWrite <= dirWrite;
        end
        ISSUE: begin
          if (handshake) begin
            adrs      <= adrs + pAdrsWidth'(cmdLen);
            remaining <= remaining - cmdLen;
          end
        end
        ACK: lastWasRead <= ~dirWrite;
        default: ;
      endcase
    end
  end

endmodule
